pingpong_buffer_scheduler: RTL and testbench

- Sequences the two-bank (buff1/buff2) FIFO datapath of the FEC encoder input buffer as a block-granular ping-pong.
- Steers upstream message_data_t writes into one bank until it holds BLOCK_LEN words, then switches banks.
- Drains completed blocks to the encoder in write order.
- Sits between the upstream/downstream handshakes and the per-FIFO wr_en/rd_en/empty/full pins. Both FIFOs share data_in; this block only gates the enables.

---
 rtl/pingpong_buffer_scheduler.sv | 118 +++++++++++
 tb/tb_pingpong_buffer_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pingpong_buffer_scheduler.sv
// Block-granular ping-pong scheduler for the two-bank FEC encoder input buffer.
// Gates per-FIFO write/read enables so whole blocks are filled and drained in write order.
//
// bank state | meaning
// B_EMPTY    | no data, writable
// B_FILLING  | partially written block, writable
// B_READY    | complete block, nothing read yet
// B_DRAINING | complete block, partially read
module pingpong_buffer_scheduler #(
   parameter int BLOCK_LEN = 16,
   parameter int CNT_W     = $clog2(BLOCK_LEN)
) (
   input  logic clk,
   input  logic rst,
   input  logic wr_en,
   input  logic rd_en,
   input  logic empty_buff1,
   input  logic empty_buff2,
   input  logic full_buff1,
   input  logic full_buff2,
   output logic wr_en_buff1,
   output logic wr_en_buff2,
   output logic rd_en_buff1,
   output logic rd_en_buff2,
   output logic wr_sel,
   output logic rd_sel,
   output logic block_ready,
   output logic empty,
   output logic full,
   output logic wr_drop,
   output logic rd_err,
   output logic block_done
);

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_READY, B_DRAINING} bank_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

   bank_t            bank_q [2];
   bank_t            bank_d [2];
   logic             wr_sel_q, wr_sel_d;
   logic             rd_sel_q, rd_sel_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             wr_ok, rd_ok;
   logic             wr_last, rd_last;
   logic             wr_bank_open, rd_bank_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) bank_q[i] <= B_EMPTY;
         wr_sel_q <= 1'b0;
         rd_sel_q <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         for (int i = 0; i < 2; i++) bank_q[i] <= bank_d[i];
         wr_sel_q <= wr_sel_d;
         rd_sel_q <= rd_sel_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) bank_d[i] = bank_q[i];
      wr_sel_d     = wr_sel_q;
      rd_sel_d     = rd_sel_q;
      wr_cnt_d     = wr_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      wr_bank_open = (bank_q[wr_sel_q] == B_EMPTY) || (bank_q[wr_sel_q] == B_FILLING);
      rd_bank_full = (bank_q[rd_sel_q] == B_READY) || (bank_q[rd_sel_q] == B_DRAINING);
      // Reset overrides handshakes so no strobe reaches the FIFOs while they are being cleared.
      wr_ok   = !rst && wr_en && wr_bank_open && !(wr_sel_q ? full_buff2 : full_buff1);
      rd_ok   = !rst && rd_en && rd_bank_full && !(rd_sel_q ? empty_buff2 : empty_buff1);
      wr_last = (wr_cnt_q == LAST);
      rd_last = (rd_cnt_q == LAST);

      if (wr_ok) begin
         if (wr_last) begin
            wr_cnt_d = '0;
            wr_sel_d = ~wr_sel_q;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end
      if (rd_ok) begin
         if (rd_last) begin
            rd_cnt_d = '0;
            rd_sel_d = ~rd_sel_q;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end

      // The write bank is never READY/DRAINING and the read bank always is, so they cannot collide.
      for (int i = 0; i < 2; i++) begin
         if (wr_ok && (wr_sel_q == i[0])) bank_d[i] = wr_last ? B_READY : B_FILLING;
         if (rd_ok && (rd_sel_q == i[0])) bank_d[i] = rd_last ? B_EMPTY : B_DRAINING;
      end
   end

   assign wr_en_buff1 = wr_ok && !wr_sel_q;
   assign wr_en_buff2 = wr_ok &&  wr_sel_q;
   assign rd_en_buff1 = rd_ok && !rd_sel_q;
   assign rd_en_buff2 = rd_ok &&  rd_sel_q;
   assign wr_drop     = !rst && wr_en && !wr_ok;
   assign rd_err      = !rst && rd_en && !rd_ok;
   assign block_done  = rd_ok && rd_last;

   assign wr_sel      = wr_sel_q;
   assign rd_sel      = rd_sel_q;
   assign full        = (bank_q[wr_sel_q] == B_READY) || (bank_q[wr_sel_q] == B_DRAINING);
   assign block_ready = (bank_q[0] == B_READY) || (bank_q[0] == B_DRAINING) ||
                        (bank_q[1] == B_READY) || (bank_q[1] == B_DRAINING);
   assign empty       = !block_ready;

endmodule

// File: tb/tb_pingpong_buffer_scheduler.sv
// Self-checking bench for pingpong_buffer_scheduler: FIFO occupancy models plus a
// block-index reference model (blocks written / blocks read / position in block).
module tb_pingpong_buffer_scheduler;

   localparam int BLOCK_LEN = 16;

   logic clk = 1'b0;
   logic rst, wr_en, rd_en;
   logic empty_buff1, empty_buff2, full_buff1, full_buff2;
   logic wr_en_buff1, wr_en_buff2, rd_en_buff1, rd_en_buff2;
   logic wr_sel, rd_sel, block_ready, empty, full, wr_drop, rd_err, block_done;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: blocks fully written, blocks fully read, word position in each.
   int wb = 0, rb = 0, wpos = 0, rpos = 0;
   int occ [2];

   always #5 clk = ~clk;

   pingpong_buffer_scheduler #(.BLOCK_LEN(BLOCK_LEN)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
      .empty_buff1(empty_buff1), .empty_buff2(empty_buff2),
      .full_buff1(full_buff1), .full_buff2(full_buff2),
      .wr_en_buff1(wr_en_buff1), .wr_en_buff2(wr_en_buff2),
      .rd_en_buff1(rd_en_buff1), .rd_en_buff2(rd_en_buff2),
      .wr_sel(wr_sel), .rd_sel(rd_sel), .block_ready(block_ready),
      .empty(empty), .full(full), .wr_drop(wr_drop), .rd_err(rd_err),
      .block_done(block_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check 1ns later, advance model at posedge.
   task automatic cycle(input logic w, input logic r, input logic f1, input logic f2, input logic rs);
      logic e_wsel, e_rsel, e_full, e_ready, wacc, racc, bdone;
      logic s_w1, s_w2, s_r1, s_r2;
      @(negedge clk);
      rst = rs; wr_en = w; rd_en = r;
      empty_buff1 = (occ[0] == 0) || f1;
      empty_buff2 = (occ[1] == 0) || f2;
      full_buff1  = (occ[0] >= BLOCK_LEN);
      full_buff2  = (occ[1] >= BLOCK_LEN);

      e_wsel  = wb[0];
      e_rsel  = rb[0];
      e_full  = (wb - rb) >= 2;
      e_ready = wb > rb;
      wacc    = !rs && w && !e_full && !(e_wsel ? full_buff2 : full_buff1);
      racc    = !rs && r && e_ready && !(e_rsel ? empty_buff2 : empty_buff1);
      bdone   = racc && (rpos == BLOCK_LEN - 1);

      #1;
      check_eq("wr_en_buff1", wr_en_buff1, wacc && !e_wsel);
      check_eq("wr_en_buff2", wr_en_buff2, wacc &&  e_wsel);
      check_eq("rd_en_buff1", rd_en_buff1, racc && !e_rsel);
      check_eq("rd_en_buff2", rd_en_buff2, racc &&  e_rsel);
      check_eq("wr_drop", wr_drop, !rs && w && !wacc);
      check_eq("rd_err", rd_err, !rs && r && !racc);
      check_eq("block_done", block_done, bdone);
      if (!rs) begin
         check_eq("wr_sel", wr_sel, e_wsel);
         check_eq("rd_sel", rd_sel, e_rsel);
         check_eq("full", full, e_full);
         check_eq("block_ready", block_ready, e_ready);
         check_eq("empty", empty, !e_ready);
      end
      s_w1 = wr_en_buff1; s_w2 = wr_en_buff2;
      s_r1 = rd_en_buff1; s_r2 = rd_en_buff2;

      @(posedge clk);
      if (rs) begin
         wb = 0; rb = 0; wpos = 0; rpos = 0;
         occ[0] = 0; occ[1] = 0;
      end else begin
         // FIFO environment follows the DUT's actual strobes.
         occ[0] = occ[0] + int'(s_w1) - int'(s_r1);
         occ[1] = occ[1] + int'(s_w2) - int'(s_r2);
         if (wacc) begin
            wpos++;
            if (wpos == BLOCK_LEN) begin wpos = 0; wb++; end
         end
         if (racc) begin
            rpos++;
            if (rpos == BLOCK_LEN) begin rpos = 0; rb++; end
         end
      end
   endtask

   task automatic run(input int n, input logic w, input logic r);
      for (int i = 0; i < n; i++) cycle(w, r, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
      empty_buff1 = 1'b1; empty_buff2 = 1'b1; full_buff1 = 1'b0; full_buff2 = 1'b0;
      occ[0] = 0; occ[1] = 0;

      // Reset with both requests high.
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      check_eq("rst_empty", empty, 1'b1);
      check_eq("rst_full", full, 1'b0);
      check_eq("rst_wr_sel", wr_sel, 1'b0);
      check_eq("rst_rd_sel", rd_sel, 1'b0);

      run(16, 1'b1, 1'b0);
      #1;
      check_eq("blk1_ready", block_ready, 1'b1);
      check_eq("blk1_wr_sel", wr_sel, 1'b1);

      run(16, 1'b1, 1'b0);
      #1;
      check_eq("full_after_32", full, 1'b1);
      run(1, 1'b1, 1'b0);

      run(16, 1'b0, 1'b1);
      #1;
      check_eq("drain_rd_sel", rd_sel, 1'b1);
      check_eq("drain_full", full, 1'b0);
      run(1, 1'b1, 1'b0);

      // Line up a write completion and a read completion in the same cycle.
      run(14, 1'b1, 1'b1);
      run(1, 1'b0, 1'b1);
      run(1, 1'b1, 1'b1);
      #1;
      check_eq("sim_wr_sel", wr_sel, 1'b1);
      check_eq("sim_rd_sel", rd_sel, 1'b0);
      check_eq("sim_ready", block_ready, 1'b1);

      // FIFO claims empty mid-block.
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

      // Reset mid-block, then a clean block.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run(8, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      run(16, 1'b1, 1'b0);
      #1;
      check_eq("post_rst_ready", block_ready, 1'b1);
      check_eq("post_rst_wr_sel", wr_sel, 1'b1);
      run(16, 1'b0, 1'b1);

      // Randomized traffic with shifting write/read bias, rare faults and resets.
      for (int i = 0; i < 4000; i++) begin
         int bias;
         bias = (i / 500) % 4;
         cycle(($urandom_range(0, 7) < 2 + bias),
               ($urandom_range(0, 7) < 5 - bias),
               ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 499) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
